// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared state encoding, command constant and byte-order helper for the SPI flash reader.
package spi_flash_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_DONE, S_GAP, S_WACK} state_t;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam int XFER_BITS = 64;
  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/spi_flash_shifter.sv
// spi_flash_shifter: mode-0 SCK divider and 64-bit read-command shift engine.
module spi_flash_shifter
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [21:0] word_addr,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        done,
  output logic [31:0] rx
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(XFER_BITS - 1);
  logic                 busy;
  logic [7:0]           div;
  logic [5:0]           bit_cnt;
  logic [XFER_BITS-1:0] sr;
  assign mosi = sr[XFER_BITS-1];
  always_ff @(posedge clk) begin
    if (rst || stop) begin
      busy    <= 1'b0;
      div     <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      sr      <= '0;
      done    <= 1'b0;
      rx      <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy    <= 1'b1;
        div     <= '0;
        bit_cnt <= '0;
        sck     <= 1'b0;
        sr      <= {CMD_READ, word_addr, 2'b00, 32'h0};
        rx      <= '0;
      end else if (busy) begin
        div <= (div == DIV_LAST) ? 8'd0 : div + 8'd1;
        if (div == DIV_LAST) begin
          sck <= !sck;
          // Only the last 32 bit periods carry flash data.
          if (!sck && bit_cnt[5]) rx <= {rx[30:0], miso};
          if (sck) begin
            sr      <= sr << 1;
            bit_cnt <= bit_cnt + 6'd1;
            busy    <= bit_cnt != BIT_LAST;
            done    <= bit_cnt == BIT_LAST;
          end
        end
      end
    end
  end
endmodule

// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl: read-only memory-bus front end that fetches words from a SPI flash with command 03h.
module spi_flash_ctrl
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  state_t      state;
  logic [7:0]  gap_cnt;
  logic        start, stop, done;
  logic [31:0] rx;
  logic        unused_bits;
  assign unused_bits = ^{mem_wdata, mem_addr[31:24], mem_addr[1:0]};
  always_comb begin
    start = state == S_IDLE && mem_valid && mem_wstrb == 4'h0;
    stop  = state == S_SHIFT && !mem_valid;
  end
  spi_flash_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .word_addr(mem_addr[23:2]),
    .miso     (spi_miso),
    .sck      (spi_sck),
    .mosi     (spi_mosi),
    .done     (done),
    .rx       (rx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      spi_cs_n  <= 1'b1;
      gap_cnt   <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      case (state)
        S_IDLE: if (mem_valid) begin
          state     <= (mem_wstrb == 4'h0) ? S_SHIFT : S_WACK;
          spi_cs_n  <= mem_wstrb != 4'h0;
          mem_ready <= mem_wstrb != 4'h0;
        end
        S_WACK: state <= S_IDLE;
        S_SHIFT: if (!mem_valid || done) begin
          // A dropped request wins over a simultaneous completion.
          state     <= mem_valid ? S_DONE : S_GAP;
          spi_cs_n  <= 1'b1;
          mem_ready <= mem_valid;
          mem_rdata <= mem_valid ? bswap(rx) : 32'h0;
          gap_cnt   <= '0;
        end
        S_DONE: begin
          state   <= S_GAP;
          gap_cnt <= '0;
        end
        S_GAP: begin
          gap_cnt <= (gap_cnt == GAP_LAST) ? 8'd0 : gap_cnt + 8'd1;
          state   <= (gap_cnt == GAP_LAST) ? S_IDLE : S_GAP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_ctrl.sv
// tb_spi_flash_ctrl: directed checks of spi_flash_ctrl at CLK_DIV=2 and CLK_DIV=1 against a byte[a]=a[7:0] flash model.
module tb_spi_flash_ctrl;
  logic        clk = 0, rst = 1;
  logic        valid [2], ready [2], cs_n [2], sck [2], mosi [2], miso [2];
  logic [31:0] addr [2], rdata [2], wdata [2];
  logic [3:0]  wstrb [2];
  int          total = 0, bad = 0;
  always #5 clk = !clk;
  spi_flash_ctrl #(.CLK_DIV(2), .CS_GAP(4)) dut0 (
    .clk(clk), .rst(rst), .mem_valid(valid[0]), .mem_ready(ready[0]), .mem_addr(addr[0]),
    .mem_rdata(rdata[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .spi_cs_n(cs_n[0]),
    .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );
  spi_flash_ctrl #(.CLK_DIV(1), .CS_GAP(4)) dut1 (
    .clk(clk), .rst(rst), .mem_valid(valid[1]), .mem_ready(ready[1]), .mem_addr(addr[1]),
    .mem_rdata(rdata[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .spi_cs_n(cs_n[1]),
    .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );
  for (genvar g = 0; g < 2; g++) begin : fl
    int          cnt = 0, lowc = 0, hi = 0, gap = 0, rdy = 0, dbl = 0;
    logic [31:0] hdr = 0;
    logic [23:0] a;
    logic [7:0]  b;
    bit          dz = 0, prv = 0;
    always @(posedge sck[g] or posedge cs_n[g])
      if (cs_n[g]) cnt = 0;
      else begin
        if (cnt < 32) hdr = {hdr[30:0], mosi[g]};
        else dz |= mosi[g];
        cnt++;
      end
    always @(negedge sck[g]) begin
      a = hdr[23:0] + 24'((cnt - 32) / 8);
      b = a[7:0];
      miso[g] = (cnt >= 32 && cnt < 64) ? b[7 - ((cnt - 32) % 8)] : 1'b0;
    end
    always @(posedge clk) begin
      if (cs_n[g]) hi++;
      else begin
        if (hi > 0) gap = hi;
        hi = 0;
        lowc++;
      end
      if (ready[g]) begin
        rdy++;
        if (prv) dbl++;
      end
      prv = ready[g];
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic rd(input int i, input logic [31:0] a, input bit keep, output logic [31:0] d, output int n);
    addr[i] = a;
    wstrb[i] = 4'h0;
    valid[i] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready[i] && n < 1000);
    if (!ready[i]) chk("rd_timeout", 32'(n), 32'd0);
    d = rdata[i];
    if (!keep) valid[i] = 1'b0;
  endtask
  initial begin
    logic [31:0] d;
    int n, c;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 0; addr[i] = 0; wdata[i] = 32'hdeadbeef; wstrb[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n[0]), 32'd1);
    chk("rst_sck", 32'(sck[0]), 32'd0);
    chk("rst_mosi", 32'(mosi[0]), 32'd0);
    chk("rst_ready", 32'(ready[0]), 32'd0);
    chk("rst_rdata", rdata[0], 32'd0);
    rst = 0;
    repeat (2) @(negedge clk);
    rd(0, 32'h01000104, 0, d, n);
    chk("rd104_data", d, 32'h07060504);
    chk("rd104_lat", 32'(n), 32'd258);
    chk("rd104_mosi", fl[0].hdr, 32'h03000104);
    repeat (10) @(negedge clk);
    c = fl[0].lowc;
    wstrb[0] = 4'hF; addr[0] = 32'h01000000; valid[0] = 1;
    @(negedge clk);
    chk("wr_ready", 32'(ready[0]), 32'd1);
    chk("wr_rdata", rdata[0], 32'd0);
    valid[0] = 0; wstrb[0] = 0;
    @(negedge clk);
    chk("wr_pulse", 32'(ready[0]), 32'd0);
    repeat (5) @(negedge clk);
    chk("wr_no_cs", 32'(fl[0].lowc - c), 32'd0);
    rd(0, 32'h01000000, 1, d, n);
    chk("b2b_first", d, 32'h03020100);
    rd(0, 32'h01000010, 0, d, n);
    chk("b2b_second", d, 32'h13121110);
    chk("b2b_gap_ge4", 32'(fl[0].gap >= 4), 32'd1);
    repeat (10) @(negedge clk);
    c = fl[0].rdy;
    addr[0] = 32'h01000104; valid[0] = 1;
    repeat (40) @(negedge clk);
    chk("abort_cs_low", 32'(cs_n[0]), 32'd0);
    valid[0] = 0;
    @(negedge clk);
    chk("abort_cs_n", 32'(cs_n[0]), 32'd1);
    chk("abort_sck", 32'(sck[0]), 32'd0);
    repeat (300) @(negedge clk);
    chk("abort_no_ready", 32'(fl[0].rdy - c), 32'd0);
    rd(0, 32'h01000104, 0, d, n);
    chk("post_abort_data", d, 32'h07060504);
    chk("post_abort_lat", 32'(n), 32'd258);
    repeat (10) @(negedge clk);
    c = fl[0].rdy;
    addr[0] = 32'h01000000; valid[0] = 1;
    repeat (100) @(negedge clk);
    chk("rst_mid_cs_low", 32'(cs_n[0]), 32'd0);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_cs_n", 32'(cs_n[0]), 32'd1);
    chk("rst_mid_sck", 32'(sck[0]), 32'd0);
    rst = 0; valid[0] = 0;
    repeat (300) @(negedge clk);
    chk("rst_mid_no_ready", 32'(fl[0].rdy - c), 32'd0);
    rd(0, 32'h01000010, 0, d, n);
    chk("post_rst_data", d, 32'h13121110);
    rd(1, 32'h01000000, 0, d, n);
    chk("div1_data", d, 32'h03020100);
    chk("div1_lat", 32'(n), 32'd130);
    chk("div1_mosi", fl[1].hdr, 32'h03000000);
    repeat (10) @(negedge clk);
    chk("dummy_zero0", 32'(fl[0].dz), 32'd0);
    chk("dummy_zero1", 32'(fl[1].dz), 32'd0);
    chk("no_double_ready", 32'(fl[0].dbl + fl[1].dbl), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_flash_ctrl.md
SPI_FLASH_CTRL -- requirements
Module: spi_flash_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCK half-period; legal values 1..255.
REQ-002 SHALL have parameter CS_GAP, default 4, meaning the minimum clk cycles spi_cs_n stays high between transfers; legal values 1..255.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_valid  input  1  request, held by the master until mem_ready.
REQ-006 mem_ready  output  1  one-cycle completion pulse.
REQ-007 mem_addr  input  32  byte address; only bits [23:2] are used.
REQ-008 mem_rdata  output  32  read word, valid while mem_ready=1.
REQ-009 mem_wdata  input  32  ignored (read-only device).
REQ-010 mem_wstrb  input  4  nonzero marks a write.
REQ-011 spi_cs_n  output  1  flash chip select, active low.
REQ-012 spi_sck  output  1  SPI clock, mode 0 (idles low).
REQ-013 spi_mosi  output  1  serial data to the flash.
REQ-014 spi_miso  input  1  serial data from the flash; already synchronous to clk.

Function
REQ-015 SHALL implement the FSM IDLE -> SHIFT -> DONE -> GAP -> IDLE, plus IDLE -> WACK -> IDLE for writes.
REQ-016 IDLE with mem_valid=1 and mem_wstrb=0: latch {mem_addr[23:2],2'b00} and go to SHIFT; spi_cs_n goes low in the next cycle.
REQ-017 IDLE with mem_valid=1 and mem_wstrb!=0: go to WACK, which pulses mem_ready for one cycle with mem_rdata=0 and produces no SPI activity.
REQ-018 SHIFT SHALL send 64 bit periods, MSB first: command 8'h03, then the 24-bit address, then 32 dummy bits with mosi=0.
REQ-019 Each bit period SHALL be CLK_DIV cycles of sck low followed by CLK_DIV cycles of sck high; mosi changes only at the start of the low phase.
REQ-020 spi_miso SHALL be sampled in the clk cycle in which sck rises, for bits 32..63 only.
REQ-021 Received bytes SHALL be assembled little-endian: first byte -> rdata[7:0], fourth byte -> rdata[31:24].
REQ-022 After bit 63, DONE SHALL raise spi_cs_n and sck=0, and pulse mem_ready for exactly one cycle with the assembled word.
REQ-023 Read latency: mem_ready high exactly 2+128*CLK_DIV cycles after the accepting cycle.
REQ-024 GAP SHALL hold spi_cs_n high for CS_GAP cycles; mem_valid is ignored in GAP.
REQ-025 The next request SHALL be accepted no earlier than the first cycle back in IDLE.
REQ-026 If mem_valid drops during SHIFT, the transfer SHALL abort: cs_n high and sck low in the next cycle, go to GAP, no mem_ready.
REQ-027 mem_ready SHALL never be asserted in two consecutive cycles.
REQ-028 spi_cs_n SHALL be high whenever the FSM is in IDLE, WACK, DONE or GAP.
REQ-029 A 6-bit bit counter and an 8-bit divider counter SHALL be used; neither wraps mid-transfer.

Reset
REQ-030 While rst=1: state=IDLE, mem_ready=0, mem_rdata=0, spi_cs_n=1, spi_sck=0, spi_mosi=0, and all counters 0.
REQ-031 rst asserted mid-transfer SHALL raise spi_cs_n and lower spi_sck in the very next cycle; no mem_ready is issued for the aborted request.

Structure
REQ-032 Package spi_flash_pkg SHALL hold the FSM state encoding, CMD_READ=8'h03, and XFER_BITS=64.
REQ-033 SHALL contain one sub-module, spi_flash_shifter, which owns the divider, the sck generation, the 64-bit shift register, and a done strobe; the top-level module owns the FSM and the bus handshake.

Verification
REQ-034 CLK_DIV=2, flash model where byte[a]=a[7:0]; read mem_addr=32'h01000104 -> MOSI carries 03 00 01 04, mem_rdata=32'h07060504, mem_ready exactly 258 cycles after accept.
REQ-035 Write with mem_wstrb=4'hF, mem_addr=32'h01000000 -> mem_ready on the next cycle with rdata=0; spi_cs_n never low.
REQ-036 Back-to-back reads to 0x01000000 and 0x01000010 with mem_valid held -> rdata 32'h03020100 then 32'h13121110; spi_cs_n high for at least CS_GAP=4 cycles between the transfers.
REQ-037 mem_valid dropped at cycle 40 of a read -> spi_cs_n high at cycle 41, no mem_ready; a following read completes correctly.
REQ-038 rst pulsed at cycle 100 of a read -> spi_cs_n=1, spi_sck=0 next cycle, no mem_ready; a read after reset returns correct data.
REQ-039 CLK_DIV=1, read of 0x01000000 -> mem_ready after 130 cycles with rdata=32'h03020100.
